// File: rtl/instr_fetch_unit_pkg.sv
// Shared RV32I fetch definitions: NOP encoding, PC step and prefetch queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_unit_pkg;

    // addi x0, x0, 0 -- presented downstream whenever no instruction is available
    localparam logic [31:0] RV32I_NOP     = 32'h0000_0013;
    localparam logic [31:0] RV32I_PC_STEP = 32'd4;

    // One prefetch slot: allocated with its PC at request time, data lands later
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        filled;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_buffer.sv
// Prefetch queue: slots allocated at request, filled in order by responses, popped from the head.
// Latency: a fill is visible at the head one cycle later; head read is combinational.
// Backpressure: caller must not alloc when alloc_cnt == FIFO_DEPTH; pop only frees the slot next cycle.
//
// Ports: clk/rst (sync, active-high), flush (drop every slot), alloc/alloc_addr (new slot at tail),
//        fill/fill_data (complete oldest unfilled slot), pop (release head),
//        head_valid/head_addr/head_data (filled head slot), alloc_cnt/unfilled_cnt (occupancy).
module fetch_buffer
    import instr_fetch_unit_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             alloc,
    input  logic [31:0]      alloc_addr,
    input  logic             fill,
    input  logic [31:0]      fill_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [31:0]      head_addr,
    output logic [31:0]      head_data,
    output logic [CNT_W-1:0] alloc_cnt,
    output logic [CNT_W-1:0] unfilled_cnt
);

    fetch_entry_t     entries [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] fill_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_fill;
    logic             do_pop;

    // A stray response with nothing outstanding must not corrupt a filled slot
    assign do_fill = fill && (unfilled_cnt != '0);
    assign do_pop  = pop && head_valid;

    assign head_valid = (alloc_cnt != '0) && entries[rd_ptr].filled;
    assign head_addr  = entries[rd_ptr].addr;
    assign head_data  = entries[rd_ptr].data;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr       <= '0;
            fill_ptr     <= '0;
            rd_ptr       <= '0;
            alloc_cnt    <= '0;
            unfilled_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entries[i].filled <= 1'b0;
            end
        end else begin
            if (alloc) begin
                entries[wr_ptr] <= '{addr: alloc_addr, data: RV32I_NOP, filled: 1'b0};
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (do_fill) begin
                entries[fill_ptr].data   <= fill_data;
                entries[fill_ptr].filled <= 1'b1;
                fill_ptr                 <= fill_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            alloc_cnt    <= alloc_cnt + CNT_W'(alloc) - CNT_W'(do_pop);
            unfilled_cnt <= unfilled_cnt + CNT_W'(alloc) - CNT_W'(do_fill);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: owns the PC, issues imem word requests, queues responses, handles EX redirects.
// Latency: request -> response (>=1 cycle) -> instr_valid one cycle after the response.
// Backpressure: instr_ready low fills the queue, then imem_req_valid drops; imem responses are never stalled.
//
// Ports: clk/rst (sync, active-high); imem_req_* (valid/ready request, word address = pc);
//        imem_rsp_* (in-order responses); jump_en/jump_addr (redirect from EX);
//        instr_valid/instr_ready/instr_if/instr_addr_if (head of queue to IF/ID);
//        fetch_misalign (pulse on a rejected misaligned redirect, only with IF_MISALIGN_CHK_EN).
// Build option: define IF_MISALIGN_CHK_EN to reject redirects whose target is not word aligned.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_if,
    output logic [31:0] instr_addr_if,
    output logic        fetch_misalign
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [31:0]      pc;
    logic [CNT_W-1:0] discard;       // responses still owed for requests made before a redirect
    logic [CNT_W-1:0] alloc_cnt;
    logic [CNT_W-1:0] unfilled_cnt;
    logic [CNT_W:0]   inflight;
    logic             req_hs;
    logic             jump_take;
    logic             rsp_drop;
    logic             buf_fill;
    logic             buf_alloc;
    logic             head_valid;
    logic [31:0]      head_addr;
    logic [31:0]      head_data;

    // Outstanding memory requests = those owning a queue slot plus those being discarded
    assign inflight = {1'b0, unfilled_cnt} + {1'b0, discard};

    // Counts are pre-pop: a slot freed this cycle is only reusable next cycle
    assign imem_req_valid = !rst && (alloc_cnt < DEPTH_CNT) && (inflight < {1'b0, DEPTH_CNT});
    assign imem_req_addr  = pc;
    assign req_hs         = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (discard != '0);
    assign buf_fill = imem_rsp_valid && (discard == '0);

`ifdef IF_MISALIGN_CHK_EN
    assign jump_take = jump_en && (jump_addr[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= jump_en && (jump_addr[1:0] != 2'b00);
        end
    end
`else
    assign jump_take      = jump_en;
    assign fetch_misalign = 1'b0;
`endif

    // A request accepted in the redirect cycle carries the old pc, so it is discarded, not queued
    assign buf_alloc = req_hs && !jump_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_ADDR;
            discard <= '0;
        end else if (jump_take) begin
            pc      <= jump_addr & ~32'h3;
            // Every request still outstanding after this edge is stale. A response arriving now
            // retires one of them whether it was headed for the queue or already being dropped.
            discard <= discard + unfilled_cnt + CNT_W'(req_hs) - CNT_W'(imem_rsp_valid);
        end else begin
            if (req_hs) begin
                pc <= pc + RV32I_PC_STEP;
            end
            discard <= discard - CNT_W'(rsp_drop);
        end
    end

    fetch_buffer #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fetch_buffer (
        .clk          (clk),
        .rst          (rst),
        .flush        (jump_take),
        .alloc        (buf_alloc),
        .alloc_addr   (pc),
        .fill         (buf_fill),
        .fill_data    (imem_rsp_data),
        .pop          (instr_valid && instr_ready),
        .head_valid   (head_valid),
        .head_addr    (head_addr),
        .head_data    (head_data),
        .alloc_cnt    (alloc_cnt),
        .unfilled_cnt (unfilled_cnt)
    );

    assign instr_valid   = head_valid;
    assign instr_if      = head_valid ? head_data : RV32I_NOP;
    assign instr_addr_if = head_valid ? head_addr : 32'h0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios followed by a randomized phase, all checked
// against an in-order program-stream model (expected PC sequence + memory contents function).
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RST_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_if;
    logic [31:0] instr_addr_if;
    logic        fetch_misalign;

    instr_fetch_unit #(
        .RESET_ADDR (RST_ADDR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_if       (instr_if),
        .instr_addr_if  (instr_addr_if),
        .fetch_misalign (fetch_misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    bit mem_rdy  = 1'b1;

    // Memory model: outstanding request addresses with the cycle their response is due
    logic [31:0] memq_addr [$];
    int          memq_due  [$];

    // Program-stream model
    logic [31:0] exp_next;     // PC of the next instruction IF/ID must receive
    logic [31:0] req_pc;       // PC of the next request the fetch unit must issue
    bit          exp_mis;
    bit          prev_stall;
    logic [31:0] prev_addr;

    logic        s_req_valid;
    logic [31:0] s_req_addr;
    logic        s_iv;
    logic [31:0] s_if;
    logic [31:0] s_ia;
    logic        s_mis;

    // Memory image: addi xN, x0, N style words, 0x00100093 at 0x0, 0x00200113 at 0x4, ...
    function automatic logic [31:0] instr_word(input logic [31:0] a);
        logic [11:0] imm;
        logic [4:0]  rd;
        imm = (a[13:2] + 12'd1) ^ a[31:20];
        rd  = a[6:2] + 5'd1;
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive memory-side inputs for this cycle and sample DUT outputs away from the edge
    task automatic sample();
        imem_req_ready = mem_rdy;
        if (!rst && memq_due.size() > 0 && memq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_word(memq_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_req_addr  = imem_req_addr;
        s_iv        = instr_valid;
        s_if        = instr_if;
        s_ia        = instr_addr_if;
        s_mis       = fetch_misalign;
    endtask

    // Model checks for the sampled cycle, then advance one clock
    task automatic finish();
        bit          hs;
        bit          taken;
        logic [31:0] tgt;
        hs = s_req_valid && imem_req_ready;
        if (rst) begin
            memq_addr.delete();
            memq_due.delete();
            exp_next   = RST_ADDR;
            req_pc     = RST_ADDR;
            exp_mis    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("misalign_pulse", {31'd0, s_mis}, {31'd0, exp_mis});
            if (prev_stall) begin
                check("req_hold_valid", {31'd0, s_req_valid}, 32'd1);
                check("req_hold_addr", s_req_addr, prev_addr);
            end
            if (hs) begin
                check("req_addr", s_req_addr, req_pc);
                memq_addr.push_back(s_req_addr);
                memq_due.push_back(cyc + mem_lat);
            end
            if (imem_rsp_valid) begin
                void'(memq_addr.pop_front());
                void'(memq_due.pop_front());
            end
            if (s_iv) begin
                if (instr_ready) begin
                    check("out_addr", s_ia, exp_next);
                    check("out_data", s_if, instr_word(exp_next));
                    exp_next = exp_next + 32'd4;
                end
            end else begin
                check("idle_instr", s_if, NOP);
                check("idle_addr", s_ia, 32'd0);
            end
            check("inflight_limit", {31'd0, memq_addr.size() <= DEPTH}, 32'd1);
`ifdef IF_MISALIGN_CHK_EN
            taken   = jump_en && (jump_addr[1:0] == 2'b00);
            exp_mis = jump_en && !taken;
`else
            taken   = jump_en;
            exp_mis = 1'b0;
`endif
            tgt = {jump_addr[31:2], 2'b00};
            if (taken) begin
                req_pc   = tgt;
                exp_next = tgt;
            end else if (hs) begin
                req_pc = req_pc + 32'd4;
            end
            prev_stall = s_req_valid && !imem_req_ready && !taken;
            prev_addr  = s_req_addr;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        jump_en = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic step();
        sample();
        finish();
    endtask

    // Leaves the cycle with instr_valid=1 sampled but not finished when found
    task automatic wait_valid(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            sample();
            if (s_iv) found = 1'b1;
            else      finish();
        end
        check("wait_valid", {31'd0, found}, 32'd1);
    endtask

    bit          found;
    int          n_hs;
    logic [31:0] r;

    initial begin
        rst            = 1'b1;
        jump_en        = 1'b0;
        jump_addr      = 32'h0;
        instr_ready    = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        @(negedge clk);

        // Reset values
        rst = 1'b1; step();
        rst = 1'b1; sample();
        check("rst_req_valid", {31'd0, s_req_valid}, 32'd0);
        check("rst_instr_valid", {31'd0, s_iv}, 32'd0);
        check("rst_instr_if", s_if, NOP);
        check("rst_instr_addr", s_ia, 32'd0);
        check("rst_misalign", {31'd0, s_mis}, 32'd0);
        finish();

        // Streaming from reset, 1-cycle memory; a slot frees only the cycle after its pop
        sample();
        check("c0_req_valid", {31'd0, s_req_valid}, 32'd1);
        check("c0_req_addr", s_req_addr, 32'h0);
        check("c0_instr_valid", {31'd0, s_iv}, 32'd0);
        finish();
        sample();
        check("c1_req_addr", s_req_addr, 32'h4);
        check("c1_instr_valid", {31'd0, s_iv}, 32'd0);
        finish();
        sample();
        check("c2_req_valid", {31'd0, s_req_valid}, 32'd0);
        check("c2_instr_addr", s_ia, 32'h0);
        check("c2_instr_if", s_if, 32'h0010_0093);
        finish();
        sample();
        check("c3_req_addr", s_req_addr, 32'h8);
        check("c3_instr_addr", s_ia, 32'h4);
        check("c3_instr_if", s_if, 32'h0020_0113);
        finish();
        repeat (20) step();

        // Mid-stream reset, then IF/ID stalled for 5 cycles
        instr_ready = 1'b0;
        rst = 1'b1; step();
        n_hs = 0;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i == 0) begin
                check("mid_rst_instr_valid", {31'd0, s_iv}, 32'd0);
                check("mid_rst_instr_if", s_if, NOP);
                check("mid_rst_req_addr", s_req_addr, RST_ADDR);
                check("mid_rst_req_valid", {31'd0, s_req_valid}, 32'd1);
            end
            if (s_req_valid && imem_req_ready) n_hs++;
            finish();
        end
        sample();
        check("stall_req_count", n_hs, 32'd2);
        check("stall_req_valid", {31'd0, s_req_valid}, 32'd0);
        check("stall_hold_addr", s_ia, 32'h0);
        check("stall_hold_instr", s_if, 32'h0010_0093);
        instr_ready = 1'b1;
        finish();
        repeat (20) step();

        // 3-cycle memory, redirect with two requests outstanding
        mem_lat = 3;
        rst = 1'b1; step();
        step();
        step();
        jump_en = 1'b1; jump_addr = 32'h100;
        sample();
        check("lat3_full_no_req", {31'd0, s_req_valid}, 32'd0);
        finish();
        sample();
        check("lat3_after_jump_valid", {31'd0, s_iv}, 32'd0);
        finish();
        wait_valid(30, found);
        if (found) begin
            check("lat3_first_addr", s_ia, 32'h100);
            check("lat3_first_data", s_if, instr_word(32'h100));
            finish();
        end
        repeat (10) step();

        // Redirect coincident with a request handshake and a response
        mem_lat = 1;
        rst = 1'b1; step();
        step();
        jump_en = 1'b1; jump_addr = 32'h200;
        sample();
        check("coin_req_valid", {31'd0, s_req_valid}, 32'd1);
        finish();
        sample();
        check("coin_after_jump_valid", {31'd0, s_iv}, 32'd0);
        finish();
        wait_valid(30, found);
        if (found) begin
            check("coin_first_addr", s_ia, 32'h200);
            finish();
        end
        repeat (10) step();

        // Misaligned redirect target
        rst = 1'b1; step();
        step();
        jump_en = 1'b1; jump_addr = 32'h102;
        step();
        sample();
`ifdef IF_MISALIGN_CHK_EN
        check("mis_pulse", {31'd0, s_mis}, 32'd1);
        check("mis_no_flush_valid", {31'd0, s_iv}, 32'd1);
        check("mis_no_flush_addr", s_ia, 32'h0);
`else
        check("mis_pulse", {31'd0, s_mis}, 32'd0);
        check("mis_flush_valid", {31'd0, s_iv}, 32'd0);
`endif
        finish();
        sample();
        check("mis_pulse_end", {31'd0, s_mis}, 32'd0);
        finish();
        wait_valid(30, found);
        if (found) begin
`ifdef IF_MISALIGN_CHK_EN
            check("mis_seq_addr", s_ia, 32'h4);
`else
            check("mis_target_addr", s_ia, 32'h100);
`endif
            finish();
        end
        repeat (10) step();

        // PC wrap at the top of the address space
        jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step();
        wait_valid(30, found);
        if (found) begin
            check("wrap_top_addr", s_ia, 32'hFFFF_FFFC);
            finish();
        end
        wait_valid(30, found);
        if (found) begin
            check("wrap_zero_addr", s_ia, 32'h0);
            finish();
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 0) mem_lat = $urandom_range(1, 4);
            instr_ready = ($urandom_range(0, 3) != 0);
            mem_rdy     = ($urandom_range(0, 3) != 0);
            r = $urandom;
            if (r[31:28] == 4'h0) begin
                jump_en   = 1'b1;
                jump_addr = {22'd0, r[9:0]} & (r[11] ? 32'h0000_03FF : 32'h0000_03FC);
                if (r[15:12] == 4'h0) jump_addr = 32'hFFFF_FFF0 | {28'd0, r[3:0]};
            end
            if (r[27:21] == 7'h0) rst = 1'b1;
            step();
        end
        instr_ready = 1'b1;
        mem_rdy     = 1'b1;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
